uart_rx: RTL and testbench

UART receiver for the `Top` serial port: 8N1 frames on `rx` are deserialised into bytes delivered over a valid/ready interface. It is the receive-side counterpart of the existing transmit path and sits between the `rx` pin and the CPU's memory-mapped UART register. A small FIFO absorbs bytes while the core is stalled, and line errors are flagged.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 66 ++++++
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the transmitter that will
// import it later): receiver FSM state type, default baud divisor and the
// number of data bits per frame.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO that buffers received bytes while the consumer is
// stalled. A push while full is accepted only when a pop happens in the same
// cycle (the pop frees the slot first).
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous reset, active low
//   push   - write din (ignored when full without a simultaneous pop)
//   pop    - remove head entry (ignored when empty)
//   din    - write data
//   dout   - head entry, valid while !empty
//   full   - DEPTH entries stored
//   empty  - no entries stored
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_doPop;
  logic             w_doPush;

  // The extra MSB on each pointer tells a wrapped (full) FIFO from an empty one.
  assign empty    = (r_wrPtr == r_rdPtr);
  assign full     = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);
  assign dout     = r_mem[r_rdPtr[AW-1:0]];

  // Storage is cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr[AW-1:0]] <= din;
        r_wrPtr                <= r_wrPtr + PTR_ONE;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The serial line is synchronised, start edges are
// detected, each bit is sampled at mid-bit, and completed bytes are queued in
// a small FIFO presented on a valid/ready interface.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous reset, active low
//   rx        - serial input, idle high, asynchronous to clk
//   rx_data   - byte at the FIFO head
//   rx_valid  - FIFO holds at least one byte
//   rx_ready  - consumer takes the head byte when rx_valid is high
//   frame_err - one-cycle pulse when a stop bit is sampled low
//   overrun   - sticky: a good byte was dropped because the FIFO was full
//   err_clr   - clears overrun (a same-cycle set wins)
//   busy      - receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int          CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = 1;

  uart_rx_state_t              r_state;
  uart_rx_state_t              w_nextState;
  logic                        r_sync1;
  logic                        r_sync2;
  logic                        r_rxsPrev;
  logic [CW-1:0]               r_baudCnt;
  logic [2:0]                  r_bitCnt;
  logic [UART_DATA_BITS-1:0]   r_shift;
  logic                        r_frameErr;
  logic                        r_overrun;
  logic                        w_tick;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_overrunSet;
  logic                        w_frameErrSet;
  logic                        w_full;
  logic                        w_empty;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // All flops reset to the idle line level so reset never looks like a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rxsPrev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rxsPrev <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  assign w_pop = !w_empty && rx_ready;

  // Next state and sample strobes. The stop sample is at mid-bit, so the
  // remaining half stop bit is spent in IDLE ready for a back-to-back start.
  always_comb begin
    w_nextState   = r_state;
    w_tick        = 1'b0;
    w_push        = 1'b0;
    w_overrunSet  = 1'b0;
    w_frameErrSet = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rxsPrev && !r_sync2) begin
          w_nextState = START;
        end
      end
      START: begin
        if (r_baudCnt == HALF_LAST) begin
          w_tick      = 1'b1;
          w_nextState = r_sync2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_baudCnt == BIT_LAST) begin
          w_tick = 1'b1;
          if (r_bitCnt == 3'd7) begin
            w_nextState = STOP;
          end
        end
      end
      STOP: begin
        if (r_baudCnt == BIT_LAST) begin
          w_tick = 1'b1;
          if (r_sync2) begin
            w_nextState = IDLE;
            if (!w_full || w_pop) begin
              w_push = 1'b1;
            end else begin
              w_overrunSet = 1'b1;
            end
          end else begin
            w_frameErrSet = 1'b1;
            w_nextState   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (r_sync2) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Baud/bit counters and the shift register. Counters sit at zero while idle,
  // which also serves as the load-with-zero on a detected start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baudCnt  <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (r_state == IDLE || r_state == WAIT_IDLE || w_tick) begin
        r_baudCnt <= '0;
      end else begin
        r_baudCnt <= r_baudCnt + CNT_ONE;
      end
      if (r_state == IDLE) begin
        r_bitCnt <= '0;
      end else if (r_state == DATA && w_tick) begin
        r_bitCnt <= r_bitCnt + 3'd1;
      end
      if (r_state == DATA && w_tick) begin
        r_shift <= {r_sync2, r_shift[UART_DATA_BITS-1:1]};
      end
      r_frameErr <= w_frameErrSet;
      r_overrun  <= w_overrunSet | (r_overrun & ~err_clr);
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(UART_DATA_BITS)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .din  (r_shift),
    .dout (rx_data),
    .full (w_full),
    .empty(w_empty)
  );

  assign rx_valid  = !w_empty;
  assign frame_err = r_frameErr;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are serialised by the bench and a
// queue-based model of delivered bytes, frame errors and overrun is kept
// alongside; a negedge process compares every valid byte against the model.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .err_clr  (err_clr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] expQ[$];
  bit         expOverrun   = 1'b0;
  int         expFrameErr  = 0;
  int         frameErrSeen = 0;
  int         validCycles  = 0;
  int         popCount     = 0;
  int         riseCyc      = -1;
  int         fallCyc      = 0;
  logic [7:0] lastPopData  = 8'h00;
  bit         prevValid    = 1'b0;
  bit         randReady    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every cycle the FIFO head is valid it must equal the oldest byte the
  // model expects; a handshake retires that byte from the model.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) frameErrSeen++;
      if (rx_valid) begin
        validCycles++;
        if (!prevValid) riseCyc = cyc;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_valid: got data %0h expected no byte", rx_data);
        end else begin
          checkOutput("rx_data", {24'h0, rx_data}, {24'h0, expQ[0]});
        end
        if (rx_ready) begin
          if (expQ.size() > 0) void'(expQ.pop_front());
          lastPopData = rx_data;
          popCount++;
        end
      end
      prevValid = rx_valid;
    end else begin
      prevValid = 1'b0;
    end
  end

  // Inputs change 2 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
    if (randReady) rx_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Outcome of a frame from the receiver's rules: good stop bit queues the
  // byte unless DEPTH bytes are already waiting; a low stop bit is an error.
  task automatic modelFrame(input logic [7:0] b, input logic stopBit);
    if (stopBit) begin
      if (expQ.size() < DEPTH) expQ.push_back(b);
      else expOverrun = 1'b1;
    end else begin
      expFrameErr++;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    fallCyc = cyc;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stopBit;
    repeat (4) tick();
    modelFrame(b, stopBit);
    repeat (CPB - 4) tick();
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || rx_valid) && n < 300) begin
      tick();
      n++;
    end
    checkOutput({name, "_model_empty"}, expQ.size(), 0);
    checkOutput({name, "_valid_low"}, {31'h0, rx_valid}, 0);
  endtask

  initial begin
    int v0, p0, f0, n, d;
    bit sawBusy;
    logic [7:0] b;
    logic sb;

    // Reset state
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) tick();
    checkOutput("reset_rx_valid", {31'h0, rx_valid}, 0);
    checkOutput("reset_rx_data", {24'h0, rx_data}, 0);
    checkOutput("reset_frame_err", {31'h0, frame_err}, 0);
    checkOutput("reset_overrun", {31'h0, overrun}, 0);
    checkOutput("reset_busy", {31'h0, busy}, 0);
    rst = 1'b1;
    repeat (5) tick();

    // Single frame 0xA5 with ready held high
    rx_ready = 1'b1;
    v0 = validCycles;
    p0 = popCount;
    applyStimulus(8'hA5, 1'b1);
    repeat (10) tick();
    d = riseCyc - fallCyc;
    checkOutput("a5_latency_in_window", {31'h0, (d >= 154 && d <= 156)}, 1);
    checkOutput("a5_valid_cycles", validCycles - v0, 1);
    checkOutput("a5_pops", popCount - p0, 1);
    checkOutput("a5_data_literal", {24'h0, lastPopData}, 32'hA5);
    checkOutput("a5_frame_err", frameErrSeen, 0);
    checkOutput("a5_overrun", {31'h0, overrun}, 0);

    // Back-to-back frames with no idle gap
    p0 = popCount;
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h55, 1'b1);
    repeat (10) tick();
    checkOutput("b2b_pops", popCount - p0, 3);
    checkOutput("b2b_last_literal", {24'h0, lastPopData}, 32'h55);
    checkOutput("b2b_model_empty", expQ.size(), 0);
    checkOutput("b2b_frame_err", frameErrSeen, expFrameErr);

    // Short low glitch on an idle line
    v0 = validCycles;
    sawBusy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sawBusy |= busy;
    end
    rx = 1'b1;
    n = 0;
    while (busy && n < 9) begin
      tick();
      n++;
    end
    checkOutput("glitch_busy_seen", {31'h0, sawBusy}, 1);
    checkOutput("glitch_busy_clear", {31'h0, busy}, 0);
    repeat (20) tick();
    checkOutput("glitch_no_valid", validCycles - v0, 0);
    checkOutput("glitch_no_frame_err", frameErrSeen, 0);

    // Bad stop bit, line then held low (break)
    v0 = validCycles;
    f0 = frameErrSeen;
    applyStimulus(8'h3C, 1'b0);
    repeat (40) tick();
    checkOutput("break_busy_held", {31'h0, busy}, 1);
    checkOutput("break_one_pulse", frameErrSeen - f0, 1);
    checkOutput("break_model_err", frameErrSeen, expFrameErr);
    checkOutput("break_no_valid", validCycles - v0, 0);
    rx = 1'b1;
    n = 0;
    while (busy && n < 8) begin
      tick();
      n++;
    end
    checkOutput("break_busy_release", {31'h0, busy}, 0);
    repeat (5) tick();

    // Five frames with consumer stalled: fifth is dropped
    rx_ready = 1'b0;
    p0 = popCount;
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1);
    repeat (4) tick();
    checkOutput("ovr_flag_model", {31'h0, overrun}, {31'h0, expOverrun});
    checkOutput("ovr_flag_literal", {31'h0, overrun}, 1);
    checkOutput("ovr_head_literal", {24'h0, rx_data}, 32'h01);
    rx_ready = 1'b1;
    waitDrain("ovr_drain");
    checkOutput("ovr_pops", popCount - p0, 4);
    checkOutput("ovr_last_literal", {24'h0, lastPopData}, 32'h04);
    checkOutput("ovr_sticky", {31'h0, overrun}, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    expOverrun = 1'b0;
    tick();
    checkOutput("ovr_cleared", {31'h0, overrun}, 0);

    // Reset in the middle of a frame, then a clean frame
    p0 = popCount;
    b = 8'h77;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rst = 1'b0;
    rx  = 1'b1;
    repeat (2) tick();
    checkOutput("midrst_busy", {31'h0, busy}, 0);
    checkOutput("midrst_valid", {31'h0, rx_valid}, 0);
    rst = 1'b1;
    repeat (3) tick();
    applyStimulus(8'h12, 1'b1);
    repeat (10) tick();
    checkOutput("midrst_pops", popCount - p0, 1);
    checkOutput("midrst_data_literal", {24'h0, lastPopData}, 32'h12);
    checkOutput("midrst_frame_err", frameErrSeen, expFrameErr);

    // Random bytes, occasional bad stop bits, random consumer stalls
    randReady = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      applyStimulus(b, sb);
      rx = 1'b1;
      n = sb ? $urandom_range(0, 10) : 10 + $urandom_range(0, 10);
      repeat (n) tick();
    end
    randReady = 1'b0;
    rx_ready = 1'b1;
    waitDrain("rand_drain");
    checkOutput("rand_frame_err", frameErrSeen, expFrameErr);
    checkOutput("rand_overrun", {31'h0, overrun}, {31'h0, expOverrun});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
